// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the decode-stage PC-select logic.
package pc_fetch_unit_pkg;

    // PC-select codes produced by decode and consumed by fetch
    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_JAL   = 2'b01;
    localparam logic [1:0] PCSEL_BR    = 2'b10;
    localparam logic [1:0] PCSEL_RSVD  = 2'b11;

    // Fetch sequencing states
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A taken JAL or branch/JALR changes control flow
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PCSEL_JAL) || (sel == PCSEL_BR);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Next-PC selection: priority mux plus sequential adder, no state.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        boot_i,
    input  logic        stall_i,
    input  logic [1:0]  pc_sel_i,
    input  logic [31:0] pc_q_i,
    input  logic [31:0] jal_target_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_next_o
);

    // Redirects beat stall: a stalled instruction is wrong-path once a redirect fires.
    // The reserved code falls through to the sequential path.
    always_comb begin
        pc_next_o = pc_q_i + 32'd4;
        if (boot_i) begin
            pc_next_o = RESET_PC;
        end else if (pc_sel_i == PCSEL_BR) begin
            pc_next_o = br_target_i;
        end else if (pc_sel_i == PCSEL_JAL) begin
            pc_next_o = jal_target_i;
        end else if (stall_i) begin
            pc_next_o = pc_q_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, IMEM/BIOS fetch addressing, wrong-path squash and redirect counting.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      jal_target,
    input  logic [31:0]      br_target,
    output logic [31:0]      imem_addr,
    output logic             imem_en,
    output logic [31:0]      fetch_pc,
    output logic             fetch_valid,
    output logic             kill_id,
    output logic             sel_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic               sel_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               redirect;
    logic               rsvd_seen;

    pc_next_mux #(
        .RESET_PC (RESET_PC)
    ) u_pc_next_mux (
        .boot_i       (state_q == ST_BOOT),
        .stall_i      (stall),
        .pc_sel_i     (pc_sel),
        .pc_q_i       (pc_q),
        .jal_target_i (jal_target),
        .br_target_i  (br_target),
        .pc_next_o    (pc_d)
    );

    // Next state and fetch tagging; reset forces the memory port idle
    always_comb begin
        state_d     = state_q;
        imem_en     = 1'b0;
        fetch_valid = 1'b0;
        kill_id     = 1'b0;
        redirect    = 1'b0;
        rsvd_seen   = 1'b0;
        if (!rst_n) begin
            state_d = ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    imem_en = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    imem_en  = 1'b1;
                    redirect = is_redirect(pc_sel);
                    case (pc_sel)
                        PCSEL_JAL:  fetch_valid = 1'b0;
                        PCSEL_BR:   kill_id     = 1'b1;
                        PCSEL_RSVD: begin
                            fetch_valid = 1'b1;
                            rsvd_seen   = 1'b1;
                        end
                        default:    fetch_valid = 1'b1;
                    endcase
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State, PC, sticky error flag and redirect counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (rsvd_seen) begin
                sel_err_q <= 1'b1;
            end
            if (redirect) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign imem_addr    = rst_n ? pc_d : RESET_PC;
    assign fetch_pc     = pc_q;
    assign sel_err      = sel_err_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes expected outputs from a
// behavioural model, monitor pops and compares on the falling edge.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] jal_target = '0;
    logic [31:0] br_target = '0;

    logic [31:0] imem_addr, fetch_pc;
    logic        imem_en, fetch_valid, kill_id, sel_err;
    logic [31:0] redirect_cnt;

    logic [31:0] imem_addr4, fetch_pc4;
    logic        imem_en4, fetch_valid4, kill_id4, sel_err4;
    logic [3:0]  redirect_cnt4;

    pc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel),
        .jal_target(jal_target), .br_target(br_target),
        .imem_addr(imem_addr), .imem_en(imem_en), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .kill_id(kill_id), .sel_err(sel_err),
        .redirect_cnt(redirect_cnt)
    );

    pc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel),
        .jal_target(jal_target), .br_target(br_target),
        .imem_addr(imem_addr4), .imem_en(imem_en4), .fetch_pc(fetch_pc4),
        .fetch_valid(fetch_valid4), .kill_id(kill_id4), .sel_err(sel_err4),
        .redirect_cnt(redirect_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic [31:0] fpc;
        logic        fv;
        logic        kill;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: PC of the word on the read port, boot flag, sticky error, redirect total
    logic [31:0] m_pc   = RST_PC;
    bit          m_boot = 1'b1;
    bit          m_err  = 1'b0;
    int unsigned m_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle of inputs, record what the outputs must be, advance the model
    task automatic step(input logic r, input logic s, input logic [1:0] sel,
                        input logic [31:0] j, input logic [31:0] b);
        exp_t e;
        logic [31:0] target;
        @(posedge clk);
        #1;
        rst_n = r; stall = s; pc_sel = sel; jal_target = j; br_target = b;
        e.fpc = m_pc;
        e.err = m_err;
        e.cnt = m_cnt;
        if (!r) begin
            e.en = 0; e.fv = 0; e.kill = 0; e.addr = RST_PC;
            m_pc = RST_PC; m_boot = 1; m_err = 0; m_cnt = 0;
        end else if (m_boot) begin
            e.en = 1; e.fv = 0; e.kill = 0; e.addr = RST_PC;
            m_pc = RST_PC; m_boot = 0;
        end else begin
            e.en = 1;
            e.kill = (sel == 2'd2);
            e.fv = !(sel == 2'd1 || sel == 2'd2);
            if (sel == 2'd2)      target = b;
            else if (sel == 2'd1) target = j;
            else if (s)           target = m_pc;
            else                  target = m_pc + 32'd4;
            if (sel == 2'd1 || sel == 2'd2) m_cnt = m_cnt + 1;
            if (sel == 2'd3) m_err = 1;
            e.addr = target;
            m_pc = target;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every cycle for which an expectation exists
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr",    imem_addr,            e.addr);
            chk("imem_en",      {31'b0, imem_en},     {31'b0, e.en});
            chk("fetch_pc",     fetch_pc,             e.fpc);
            chk("fetch_valid",  {31'b0, fetch_valid}, {31'b0, e.fv});
            chk("kill_id",      {31'b0, kill_id},     {31'b0, e.kill});
            chk("sel_err",      {31'b0, sel_err},     {31'b0, e.err});
            chk("redirect_cnt", redirect_cnt,         e.cnt);
            chk("imem_addr_w4", imem_addr4,           e.addr);
            chk("ctl_w4", {28'b0, imem_en4, fetch_valid4, kill_id4, sel_err4},
                          {28'b0, e.en, e.fv, e.kill, e.err});
            chk("fetch_pc_w4",  fetch_pc4,            e.fpc);
            chk("redirect_cnt_w4", {28'b0, redirect_cnt4}, e.cnt & 32'hF);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // Reset cycle, boot, then sequential fetch up to 4000_0010
        step(0, 0, 2'd0, 0, 0);
        step(1, 0, 2'd0, 0, 0);
        repeat (4) step(1, 0, 2'd0, 0, 0);
        // JAL at 4000_0010
        step(1, 0, 2'd1, 32'h4000_0100, 32'h0);
        step(1, 0, 2'd0, 0, 0);
        // Branch with simultaneous stall
        step(1, 1, 2'd2, 32'h4000_0800, 32'h1000_0020);
        step(1, 0, 2'd0, 0, 0);
        // Jump to 4000_0020, then stall three cycles and release
        step(1, 0, 2'd1, 32'h4000_0020, 0);
        repeat (3) step(1, 1, 2'd0, 0, 0);
        repeat (2) step(1, 0, 2'd0, 0, 0);
        // Reserved select, sticky error, cleared by reset
        step(1, 0, 2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        repeat (2) step(1, 0, 2'd0, 0, 0);
        // Reset during a branch redirect
        step(0, 0, 2'd2, 0, 32'h2000_0000);
        step(1, 0, 2'd0, 0, 0);
        // Sixteen back-to-back redirects wrap the 4-bit counter
        for (int i = 0; i < 16; i++) step(1, 0, 2'd1, 32'h4000_0000 + 32'(i * 64), 0);
        repeat (2) step(1, 0, 2'd0, 0, 0);
        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 40) != 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
